// File: rtl/toggle_event_receiver.sv
// Recovers discrete events from a toggle-encoded level and buffers them behind a valid/ready
// handshake with a saturating pending count, a sticky overflow flag and a wrapping total.
module toggle_event_receiver #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_W       = 4,
   parameter int unsigned TOT_W       = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             t_in,
   input  logic             clr,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [CNT_W-1:0] pending,
   output logic             overflow,
   output logic [TOT_W-1:0] total
);

   localparam int unsigned WU_W = $clog2(SYNC_STAGES + 1);
   localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   sync_last;
   logic                   t_ref_q;
   logic                   armed_q;
   logic [WU_W-1:0]        warm_q;
   logic                   evt_edge;
   logic                   dec;
   logic [CNT_W-1:0]       pending_q;
   logic                   overflow_q;
   logic [TOT_W-1:0]       total_q;

   assign sync_d    = {sync_q[SYNC_STAGES-2:0], t_in};
   assign sync_last = sync_q[SYNC_STAGES-1];
   assign evt_edge  = armed_q & (sync_last ^ t_ref_q);
   assign evt_valid = (pending_q != '0);
   assign dec       = evt_valid & evt_ready;

   assign pending  = pending_q;
   assign overflow = overflow_q;
   assign total    = total_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q  <= '0;
         t_ref_q <= 1'b0;
         armed_q <= 1'b0;
         warm_q  <= '0;
      end else begin
         sync_q <= sync_d;
         if (!armed_q) begin
            // Track the level the last stage is about to hold, so a level already present
            // at reset release is never seen as a change once armed.
            t_ref_q <= sync_d[SYNC_STAGES-1];
            warm_q  <= warm_q + WU_W'(1);
            if (warm_q == WU_W'(SYNC_STAGES - 1)) begin
               armed_q <= 1'b1;
            end
         end else if (evt_edge) begin
            t_ref_q <= sync_last;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pending_q  <= '0;
         overflow_q <= 1'b0;
         total_q    <= '0;
      end else if (clr) begin
         pending_q  <= '0;
         overflow_q <= 1'b0;
         total_q    <= '0;
      end else begin
         if (evt_edge) begin
            total_q <= total_q + TOT_W'(1);
         end
         case ({evt_edge, dec})
            2'b10: begin
               if (pending_q == PEND_MAX) begin
                  overflow_q <= 1'b1;
               end else begin
                  pending_q <= pending_q + CNT_W'(1);
               end
            end
            2'b01:   pending_q <= pending_q - CNT_W'(1);
            default: pending_q <= pending_q;
         endcase
      end
   end

endmodule
